// File: rtl/dpi_seq_pkg.sv
// Shared FSM type, default widths and context reset value for the flow
// context sequencer.
package dpi_seq_pkg;

  localparam int NUM_FLOWS_DEF = 16;
  localparam int FLOW_W_DEF    = 4;
  localparam int STATE_W_DEF   = 11;
  localparam int CNT_W_DEF     = 8;
  localparam int OFF_W_DEF     = 16;

  // Saved DFA state of a flow that has never been seen (engine start state).
  localparam logic [STATE_W_DEF-1:0] CTX_RST_VAL = 11'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_SAVE   = 3'd3,
    ST_REPORT = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dpi_flow_ctx_ram.sv
// Per-flow DFA context store: NUM_FLOWS x STATE_W registers, one async read
// port, one sync write port, synchronous reset to the engine start state.
module dpi_flow_ctx_ram
  import dpi_seq_pkg::*;
#(
  parameter int NUM_FLOWS = NUM_FLOWS_DEF,
  parameter int FLOW_W    = FLOW_W_DEF,
  parameter int STATE_W   = STATE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [FLOW_W-1:0]  waddr,
  input  logic [STATE_W-1:0] wdata,
  input  logic [FLOW_W-1:0]  raddr,
  output logic [STATE_W-1:0] rdata
);

  logic [STATE_W-1:0] mem_r [NUM_FLOWS];

  // Context storage with synchronous clear-all on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        mem_r[i] <= STATE_W'(CTX_RST_VAL);
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dpi_flow_ctx_sequencer.sv
// Restores, streams and saves per-flow DFA engine state around each packet.
// Define DPI_FLOW_CLR_EN to add the clr_vld/clr_flow/clr_rdy context clear port.
module dpi_flow_ctx_sequencer
  import dpi_seq_pkg::*;
#(
  parameter int NUM_FLOWS = NUM_FLOWS_DEF,
  parameter int FLOW_W    = FLOW_W_DEF,
  parameter int STATE_W   = STATE_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int OFF_W     = OFF_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_vld,
  output logic               pkt_rdy,
  input  logic [7:0]         pkt_data,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [FLOW_W-1:0]  pkt_flow,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic               rpt_vld,
  input  logic               rpt_rdy,
  output logic [FLOW_W-1:0]  rpt_flow,
  output logic               rpt_hit,
  output logic [CNT_W-1:0]   rpt_cnt,
  output logic [OFF_W-1:0]   rpt_off,
`ifdef DPI_FLOW_CLR_EN
  input  logic               clr_vld,
  input  logic [FLOW_W-1:0]  clr_flow,
  output logic               clr_rdy,
`endif
  output logic               sop_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [OFF_W-1:0] OFF_MAX = {OFF_W{1'b1}};

  seq_state_e         state_r, state_s;
  logic [FLOW_W-1:0]  flow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [OFF_W-1:0]   off_r;
  logic [OFF_W-1:0]   idx_r;
  logic               hit_r;
  logic               sop_err_r;

  logic               start_s, stray_s, load_s, beat_s, save_s;
  logic               clr_fire_s;
  logic [FLOW_W-1:0]  clr_flow_s;
  logic               ram_we_s;
  logic [FLOW_W-1:0]  ram_waddr_s;
  logic [STATE_W-1:0] ram_wdata_s;
  logic [STATE_W-1:0] ram_rdata_s;

`ifdef DPI_FLOW_CLR_EN
  // A clear only lands while idle, so it never races the SAVE write.
  assign clr_rdy    = (state_r == ST_IDLE);
  assign clr_fire_s = clr_vld && (state_r == ST_IDLE);
  assign clr_flow_s = clr_flow;
`else
  assign clr_fire_s = 1'b0;
  assign clr_flow_s = {FLOW_W{1'b0}};
`endif

  // Next-state and handshake/engine outputs
  always_comb begin
    state_s          = state_r;
    pkt_rdy          = 1'b0;
    eng_char         = 8'h00;
    eng_char_vld     = 1'b0;
    eng_state_in     = {STATE_W{1'b0}};
    eng_state_in_vld = 1'b0;
    rpt_vld          = 1'b0;
    start_s          = 1'b0;
    stray_s          = 1'b0;
    load_s           = 1'b0;
    beat_s           = 1'b0;
    save_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_fire_s) begin
          state_s = ST_IDLE;
        end else if (pkt_vld && pkt_sop) begin
          // SOP byte is left on the bus; it is consumed as data in STREAM.
          start_s = 1'b1;
          state_s = ST_LOAD;
        end else if (pkt_vld) begin
          pkt_rdy = 1'b1;
          stray_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s           = 1'b1;
        eng_state_in     = ram_rdata_s;
        eng_state_in_vld = 1'b1;
        state_s          = ST_STREAM;
      end
      ST_STREAM: begin
        pkt_rdy      = 1'b1;
        eng_char     = pkt_data;
        eng_char_vld = pkt_vld;
        beat_s       = pkt_vld;
        if (pkt_vld && pkt_eop) begin
          state_s = ST_SAVE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_SAVE: begin
        save_s  = 1'b1;
        state_s = ST_REPORT;
      end
      ST_REPORT: begin
        rpt_vld = 1'b1;
        if (rpt_rdy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Context write port shared by end-of-packet save and idle clear
  always_comb begin
    if (save_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = flow_r;
      ram_wdata_s = eng_state_out;
    end else begin
      ram_we_s    = clr_fire_s;
      ram_waddr_s = clr_flow_s;
      ram_wdata_s = STATE_W'(CTX_RST_VAL);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Packet bookkeeping: flow latch, match counter, first-hit offset, byte index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flow_r    <= {FLOW_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      off_r     <= {OFF_W{1'b0}};
      idx_r     <= {OFF_W{1'b0}};
      hit_r     <= 1'b0;
      sop_err_r <= 1'b0;
    end else begin
      if (start_s) begin
        flow_r <= pkt_flow;
      end
      if (stray_s) begin
        sop_err_r <= 1'b1;
      end
      if (load_s) begin
        cnt_r <= {CNT_W{1'b0}};
        off_r <= {OFF_W{1'b0}};
        idx_r <= {OFF_W{1'b0}};
        hit_r <= 1'b0;
      end else if (beat_s) begin
        if (eng_accept) begin
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (!hit_r) begin
            hit_r <= 1'b1;
            off_r <= idx_r;
          end
        end
        if (idx_r != OFF_MAX) begin
          idx_r <= idx_r + {{(OFF_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign rpt_flow = flow_r;
  assign rpt_hit  = hit_r;
  assign rpt_cnt  = cnt_r;
  assign rpt_off  = off_r;
  assign sop_err  = sop_err_r;

  dpi_flow_ctx_ram #(
    .NUM_FLOWS(NUM_FLOWS),
    .FLOW_W   (FLOW_W),
    .STATE_W  (STATE_W)
  ) u_ctx_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .raddr(flow_r),
    .rdata(ram_rdata_s)
  );

endmodule

// File: tb/tb_dpi_flow_ctx_sequencer.sv
// Bench for dpi_flow_ctx_sequencer: behavioural EXPN\s+ROOT engine plus a
// per-flow context/report model, directed literal cases and random traffic.
module tb_dpi_flow_ctx_sequencer;

  typedef struct {
    logic [3:0]  flow;
    logic        hit;
    logic [7:0]  cnt;
    logic [15:0] off;
  } rpt_t;

  logic        clk, rst_n;
  logic        pkt_vld, pkt_rdy, pkt_sop, pkt_eop;
  logic [7:0]  pkt_data;
  logic [3:0]  pkt_flow;
  logic [7:0]  eng_char;
  logic        eng_char_vld, eng_state_in_vld, eng_accept;
  logic [10:0] eng_state_in, eng_state_out;
  logic        rpt_vld, rpt_rdy, rpt_hit, sop_err;
  logic [3:0]  rpt_flow;
  logic [7:0]  rpt_cnt;
  logic [15:0] rpt_off;
`ifdef DPI_FLOW_CLR_EN
  logic        clr_vld, clr_rdy;
  logic [3:0]  clr_flow;
`endif

  int          checks = 0;
  int          errors = 0;
  rpt_t        exp_q[$];
  logic [10:0] ld_q[$];
  logic [10:0] ctx_m [16];
  logic [7:0]  pkt_b[$];
  logic        exp_sop_err = 1'b0;
  logic        hold_rdy = 1'b0;
  logic [10:0] eng_s;

  dpi_flow_ctx_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_data(pkt_data),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_flow(pkt_flow),
    .eng_char(eng_char), .eng_char_vld(eng_char_vld),
    .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
    .eng_state_out(eng_state_out), .eng_accept(eng_accept),
    .rpt_vld(rpt_vld), .rpt_rdy(rpt_rdy), .rpt_flow(rpt_flow),
    .rpt_hit(rpt_hit), .rpt_cnt(rpt_cnt), .rpt_off(rpt_off),
`ifdef DPI_FLOW_CLR_EN
    .clr_vld(clr_vld), .clr_flow(clr_flow), .clr_rdy(clr_rdy),
`endif
    .sop_err(sop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Case-insensitive unanchored EXPN\s+ROOT DFA; reaching state 9 is an accept.
  function automatic logic [10:0] eng_next(input logic [10:0] s, input logic [7:0] c);
    logic [7:0]  u;
    logic        ws;
    logic [10:0] nx;
    u  = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    ws = (c == 8'h20) || (c == 8'h09);
    nx = (u == 8'h45) ? 11'd1 : 11'd0;
    case (s)
      11'd1: if (u == 8'h58) nx = 11'd2;
      11'd2: if (u == 8'h50) nx = 11'd3;
      11'd3: if (u == 8'h4e) nx = 11'd4;
      11'd4: if (ws) nx = 11'd5;
      11'd5: if (ws) nx = 11'd5; else if (u == 8'h52) nx = 11'd6;
      11'd6: if (u == 8'h4f) nx = 11'd7;
      11'd7: if (u == 8'h4f) nx = 11'd8;
      11'd8: if (u == 8'h54) nx = 11'd9;
      default: ;
    endcase
    return nx;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) eng_s <= 11'd0;
    else if (eng_state_in_vld) eng_s <= eng_state_in;
    else if (eng_char_vld) eng_s <= eng_next(eng_s, eng_char);
  end
  assign eng_state_out = eng_s;
  assign eng_accept    = eng_char_vld && (eng_next(eng_s, eng_char) == 11'd9);

  always @(posedge clk) begin
    #1;
    rpt_rdy = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model's queues
  always @(negedge clk) begin
    if (rst_n) begin
      chk("vld_exclusive", 32'(eng_char_vld && eng_state_in_vld), 32'd0);
      chk("sop_err", 32'(sop_err), 32'(exp_sop_err));
      if (eng_char_vld) chk("eng_char", 32'(eng_char), 32'(pkt_data));
      if (eng_state_in_vld) begin
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: state_in %0d with no packet pending", eng_state_in);
        end else begin
          chk("load_state", 32'(eng_state_in), 32'(ld_q[0]));
          void'(ld_q.pop_front());
        end
      end
      if (rpt_vld) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_report: flow %0d cnt %0d with none expected", rpt_flow, rpt_cnt);
        end else begin
          chk("rpt_flow", 32'(rpt_flow), 32'(exp_q[0].flow));
          chk("rpt_hit", 32'(rpt_hit), 32'(exp_q[0].hit));
          chk("rpt_cnt", 32'(rpt_cnt), 32'(exp_q[0].cnt));
          chk("rpt_off", 32'(rpt_off), 32'(exp_q[0].off));
          chk("pkt_rdy_in_report", 32'(pkt_rdy), 32'd0);
          if (rpt_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop, input logic [3:0] fl);
    bit done;
    int n;
    pkt_vld = 1'b1; pkt_data = d; pkt_sop = sop; pkt_eop = eop; pkt_flow = fl;
    done = 1'b0; n = 0;
    while (!done) begin
      @(negedge clk);
      if (pkt_rdy) done = 1'b1;
      @(posedge clk); #1;
      n++;
      if (!done && n > 300) begin
        checks++; errors++;
        $display("FAIL byte_timeout: byte %0h never accepted", d);
        done = 1'b1;
      end
    end
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_pkt(input string s);
    pkt_b.delete();
    for (int j = 0; j < s.len(); j++) pkt_b.push_back(s[j]);
  endtask

  // Model the whole packet from the flow's saved context, then drive it.
  task automatic send_pkt(input logic [3:0] fl, input bit use_lit, input int lit_ld,
                          input int lit_cnt, input int lit_off);
    logic [10:0] s, nx;
    int          c, o;
    bit          h;
    rpt_t        r;
    s = ctx_m[fl]; c = 0; o = 0; h = 1'b0;
    if (use_lit) ld_q.push_back(11'(lit_ld));
    else ld_q.push_back(s);
    foreach (pkt_b[i]) begin
      nx = eng_next(s, pkt_b[i]);
      if (nx == 11'd9) begin
        if (c != 255) c++;
        if (!h) begin h = 1'b1; o = i; end
      end
      s = nx;
    end
    ctx_m[fl] = s;
    r.flow = fl;
    if (use_lit) begin
      r.cnt = 8'(lit_cnt); r.off = 16'(lit_off); r.hit = (lit_cnt != 0);
    end else begin
      r.cnt = 8'(c); r.off = 16'(o); r.hit = h;
    end
    exp_q.push_back(r);
    foreach (pkt_b[i]) begin
      send_byte(pkt_b[i], (i == 0) || ($urandom_range(0, 7) == 0), i == pkt_b.size() - 1,
                (i == 0) ? fl : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d reports outstanding", exp_q.size());
    end
  endtask

  task automatic send_stray();
    pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'h41;
    @(negedge clk);
    chk("stray_rdy", 32'(pkt_rdy), 32'd1);
    chk("stray_no_engine", 32'(eng_char_vld || eng_state_in_vld), 32'd0);
    @(posedge clk); #1;
    pkt_vld = 1'b0;
    exp_sop_err = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rpt_vld"}, 32'(rpt_vld), 32'd0);
    chk({tag, "_pkt_rdy"}, 32'(pkt_rdy), 32'd0);
    chk({tag, "_eng_vld"}, 32'(eng_char_vld || eng_state_in_vld), 32'd0);
    chk({tag, "_sop_err"}, 32'(sop_err), 32'd0);
    chk({tag, "_rpt_fields"}, 32'({rpt_flow, rpt_hit, rpt_cnt, rpt_off}), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    string src;
    logic [3:0] fl;
    int st, ln;
    src = "EXPN ROOTexpn  rootxEXPN\tROOTqEXPNROOTEXPN ROOT RoOt";
    rst_n = 1'b0; pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
    pkt_data = 8'h00; pkt_flow = 4'd0; rpt_rdy = 1'b0;
`ifdef DPI_FLOW_CLR_EN
    clr_vld = 1'b0; clr_flow = 4'd0;
`endif
    for (int i = 0; i < 16; i++) ctx_m[i] = 11'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Whole match in one packet
    set_pkt("EXPN ROOT"); send_pkt(4'd3, 1'b1, 0, 1, 8);
    // Match split across two packets of one flow
    set_pkt("EXPN R");    send_pkt(4'd5, 1'b1, 0, 0, 0);
    set_pkt("OOT");       send_pkt(4'd5, 1'b1, 6, 1, 2);
    // Interleaved flow must not disturb flow 5's context
    set_pkt("EXPN R");    send_pkt(4'd5, 1'b1, 9, 0, 0);
    set_pkt("xyz");       send_pkt(4'd6, 1'b1, 0, 0, 0);
    set_pkt("OOT");       send_pkt(4'd5, 1'b1, 6, 1, 2);
`ifdef DPI_FLOW_CLR_EN
    set_pkt("EXPN R");    send_pkt(4'd5, 1'b1, 9, 0, 0);
    wait_drain();
    ctx_m[5] = 11'd0;
    set_pkt("OOT");
    fork
      begin
        clr_vld = 1'b1; clr_flow = 4'd5;
        @(negedge clk);
        chk("clr_rdy", 32'(clr_rdy), 32'd1);
        @(posedge clk); #1;
        clr_vld = 1'b0;
      end
      send_pkt(4'd5, 1'b1, 0, 0, 0);
    join
`endif
    // Report back-pressure: next SOP must wait, no byte lost
    wait_drain();
    hold_rdy = 1'b1;
    set_pkt("EXPN ROOT"); send_pkt(4'd3, 1'b1, 9, 1, 8);
    set_pkt("ROOT");
    fork
      send_pkt(4'd2, 1'b1, 0, 0, 0);
      begin
        repeat (7) @(posedge clk);
        #2 hold_rdy = 1'b0;
      end
    join
    // Stray non-SOP byte in IDLE
    wait_drain();
    send_stray();
    // Reset in the middle of a packet
    set_pkt("EXPN");
    ld_q.push_back(ctx_m[7]);
    foreach (pkt_b[i]) send_byte(pkt_b[i], i == 0, 1'b0, 4'd7);
    rst_n = 1'b0;
    exp_q.delete();
    exp_sop_err = 1'b0;
    for (int i = 0; i < 16; i++) ctx_m[i] = 11'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_pkt("OOT");       send_pkt(4'd3, 1'b1, 0, 0, 0);
    set_pkt("OOT");       send_pkt(4'd5, 1'b1, 0, 0, 0);
    // Counter saturation
    pkt_b.delete();
    for (int k = 0; k < 260; k++) begin
      for (int j = 0; j < 9; j++) pkt_b.push_back(src[j]);
    end
    send_pkt(4'd9, 1'b1, 0, 255, 8);
    // Random traffic over a few hot flows
    for (int k = 0; k < 80; k++) begin
      st = $urandom_range(0, src.len() - 1);
      ln = $urandom_range(1, 12);
      pkt_b.delete();
      for (int j = 0; j < ln; j++) pkt_b.push_back(src[(st + j) % src.len()]);
      fl = (k % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      send_pkt(fl, 1'b0, 0, 0, 0);
      if ($urandom_range(0, 9) == 0) begin
        wait_drain();
        send_stray();
      end
    end
    wait_drain();
    repeat (5) @(posedge clk);
    chk("loads_outstanding", 32'(ld_q.size()), 32'd0);
    chk("reports_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
